// File: rtl/rds_pkg.sv
// Shared constants and types for the RDS programme-service encoder.
package rds_pkg;

  // Generator x^10+x^8+x^7+x^5+x^4+x^3+1
  localparam logic [10:0] CRC_POLY = 11'h5B9;

  // Offset words added to each block's checkword
  localparam logic [9:0] OFS_A = 10'h0FC;
  localparam logic [9:0] OFS_B = 10'h198;
  localparam logic [9:0] OFS_C = 10'h168;
  localparam logic [9:0] OFS_D = 10'h1B4;

  localparam int GROUP_BYTES = 13;
  localparam int NUM_GROUPS  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC,
    S_APPEND,
    S_WR,
    S_SWAP
  } rds_state_t;

  typedef logic [25:0] rds_block_t;

  // Offset word for block index 0..3 (A..D)
  function automatic logic [9:0] offset_word(input logic [1:0] blk);
    case (blk)
      2'd0:    return OFS_A;
      2'd1:    return OFS_B;
      2'd2:    return OFS_C;
      default: return OFS_D;
    endcase
  endfunction

endpackage

// File: rtl/rds_crc10.sv
// Serial CRC-10 for RDS blocks, one data bit per enabled cycle, MSB first.
module rds_crc10
  import rds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [9:0] crc
);

  logic fb;

  assign fb = din ^ crc[9];

  // Clear to zero between blocks, otherwise divide in one data bit per enable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[8:0], 1'b0} ^ (fb ? CRC_POLY[9:0] : 10'd0);
    end
  end

endmodule

// File: rtl/rds_ps_encoder.sv
// Builds the four type-0A RDS groups carrying PI/PTY/flags and the PS name
// into a double-buffered 52-byte image read by the RDS modulator.
module rds_ps_encoder
  import rds_pkg::*;
#(
  parameter logic [15:0] AF_WORD   = 16'hE0CD,
  parameter int          MSG_BYTES = 52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pi,
  input  logic [4:0]  pty,
  input  logic        tp,
  input  logic        ta,
  input  logic        ms,
  input  logic [3:0]  di,
  input  logic [63:0] ps_name,
  input  logic [5:0]  rds_addr,
  output logic [7:0]  rds_data,
  output logic        busy,
  output logic        done
);

  rds_state_t   state;
  logic [15:0]  pi_q;
  logic [4:0]   pty_q;
  logic         tp_q;
  logic         ta_q;
  logic         ms_q;
  logic [3:0]   di_q;
  logic [63:0]  ps_q;
  logic [3:0]   bit_cnt;
  logic [1:0]   blk;
  logic [1:0]   grp;
  logic [3:0]   byte_cnt;
  logic [5:0]   wr_ptr;
  logic [103:0] grp_reg;
  logic         disp_bank;
  logic         valid;
  logic [15:0]  blk_data;
  logic [9:0]   crc;
  logic         crc_en;
  logic         crc_clr;
  rds_block_t   block;
  logic [7:0]   mem [0:1][0:MSG_BYTES-1];

  // Data word of the block currently being encoded
  always_comb begin
    blk_data = pi_q;
    case (blk)
      2'd0:    blk_data = pi_q;
      2'd1:    blk_data = {4'b0000, 1'b0, tp_q, pty_q, ta_q, ms_q, di_q[2'd3 - grp], grp};
      2'd2:    blk_data = AF_WORD;
      default: blk_data = ps_q[6'd63 - {grp, 4'b0000} -: 16];
    endcase
  end

  assign crc_en  = (state == S_CRC);
  assign crc_clr = (state != S_CRC);
  assign block   = {blk_data, crc ^ offset_word(blk)};

  rds_crc10 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (blk_data[4'd15 - bit_cnt]),
    .crc (crc)
  );

  // Build sequencer: CRC each block bit-serially, append it, then flush the group bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      disp_bank <= 1'b0;
      bit_cnt   <= '0;
      blk       <= '0;
      grp       <= '0;
      byte_cnt  <= '0;
      wr_ptr    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_SWAP: begin
          state <= S_IDLE;
          if (start) begin
            pi_q     <= pi;
            pty_q    <= pty;
            tp_q     <= tp;
            ta_q     <= ta;
            ms_q     <= ms;
            di_q     <= di;
            ps_q     <= ps_name;
            bit_cnt  <= '0;
            blk      <= '0;
            grp      <= '0;
            byte_cnt <= '0;
            wr_ptr   <= '0;
            busy     <= 1'b1;
            state    <= S_CRC;
          end
        end
        S_CRC: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            state <= S_APPEND;
          end
        end
        S_APPEND: begin
          grp_reg <= {grp_reg[77:0], block};
          blk     <= blk + 2'd1;
          state   <= (blk == 2'd3) ? S_WR : S_CRC;
        end
        S_WR: begin
          grp_reg  <= {grp_reg[95:0], 8'h00};
          wr_ptr   <= wr_ptr + 6'd1;
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == 4'(GROUP_BYTES - 1)) begin
            byte_cnt <= '0;
            if (grp == 2'(NUM_GROUPS - 1)) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              valid     <= 1'b1;
              disp_bank <= ~disp_bank;
              state     <= S_SWAP;
            end else begin
              grp   <= grp + 2'd1;
              state <= S_CRC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Group bytes go only into the bank that is not being displayed
  always_ff @(posedge clk) begin
    if (!rst && state == S_WR) begin
      mem[~disp_bank][wr_ptr] <= grp_reg[103:96];
    end
  end

  // Registered read of the displayed bank; empty or out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rds_data <= 8'h00;
    end else if (valid && rds_addr < 6'(MSG_BYTES)) begin
      rds_data <= mem[disp_bank][rds_addr];
    end else begin
      rds_data <= 8'h00;
    end
  end

endmodule

// File: tb/tb_rds_ps_encoder.sv
// Directed self-checking bench for rds_ps_encoder.
module tb_rds_ps_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pi;
  logic [4:0]  pty;
  logic        tp;
  logic        ta;
  logic        ms;
  logic [3:0]  di;
  logic [63:0] ps_name;
  logic [5:0]  rds_addr;
  logic [7:0]  rds_data;
  logic        busy;
  logic        done;

  int errors;
  int checks;

  logic [7:0] model_img [52];
  logic [7:0] old_img   [52];
  logic [7:0] got_img   [52];

  rds_ps_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pi       (pi),
    .pty      (pty),
    .tp       (tp),
    .ta       (ta),
    .ms       (ms),
    .di       (di),
    .ps_name  (ps_name),
    .rds_addr (rds_addr),
    .rds_data (rds_data),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Remainder of d(x)*x^10 divided by the generator polynomial
  function automatic logic [9:0] crc10(input logic [15:0] d);
    logic [25:0] r;
    r = {d, 10'b0};
    for (int i = 25; i >= 10; i--) begin
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    end
    return r[9:0];
  endfunction

  task automatic build_model(input logic [15:0] m_pi, input logic [4:0] m_pty,
                             input logic m_tp, input logic m_ta, input logic m_ms,
                             input logic [3:0] m_di, input logic [63:0] m_ps);
    logic [15:0]  da, db, dc, dd;
    logic [103:0] bits;
    for (int g = 0; g < 4; g++) begin
      da = m_pi;
      db = {4'b0000, 1'b0, m_tp, m_pty, m_ta, m_ms, m_di[3-g], 2'(g)};
      dc = 16'hE0CD;
      dd = m_ps[63-16*g -: 16];
      bits = {da, crc10(da) ^ 10'h0FC, db, crc10(db) ^ 10'h198,
              dc, crc10(dc) ^ 10'h168, dd, crc10(dd) ^ 10'h1B4};
      for (int k = 0; k < 13; k++) model_img[g*13+k] = bits[103-8*k -: 8];
    end
  endtask

  task automatic set_inputs(input logic [15:0] v_pi, input logic [4:0] v_pty,
                            input logic v_tp, input logic v_ta, input logic v_ms,
                            input logic [3:0] v_di, input logic [63:0] v_ps);
    pi = v_pi; pty = v_pty; tp = v_tp; ta = v_ta; ms = v_ms; di = v_di; ps_name = v_ps;
    build_model(v_pi, v_pty, v_tp, v_ta, v_ms, v_di, v_ps);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic read_byte(input logic [5:0] a, output logic [7:0] d);
    rds_addr = a;
    @(posedge clk); #1;
    d = rds_data;
  endtask

  task automatic read_image;
    for (int a = 0; a < 52; a++) read_byte(6'(a), got_img[a]);
  endtask

  // Observes one build from cycle 1, optionally re-pulsing start with altered inputs
  task automatic wait_build(input int start2_at, output int done_at, output int done_cnt,
                            output int busy_bad);
    done_at = -1; done_cnt = 0; busy_bad = 0;
    for (int c = 1; c <= 340; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (busy !== (c <= 324)) busy_bad++;
      if (c == start2_at) begin
        start = 1'b1; pi = 16'hBEEF; ps_name = "IGNORED!";
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    for (int a = 0; a < 64; a++) begin
      read_byte(6'(a), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_read addr=%0d got=%h want=00", a, d); end
    end
  endtask

  task automatic test_zero_build;
    int done_at, done_cnt, busy_bad;
    logic [7:0] d;
    logic [7:0] hand [4];
    hand[0] = 8'h00; hand[1] = 8'h00; hand[2] = 8'h3F; hand[3] = 8'h00;
    set_inputs(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 64'h0);
    pulse_start;
    wait_build(0, done_at, done_cnt, busy_bad);
    checks++;
    if (done_at !== 325) begin errors++; $display("[TB] FAIL zero_done_cycle got=%0d want=325", done_at); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL zero_done_count got=%0d want=1", done_cnt); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("[TB] FAIL zero_busy_window bad_cycles=%0d want=0", busy_bad); end
    read_image;
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (got_img[a] !== hand[a]) begin errors++; $display("[TB] FAIL zero_byte%0d got=%h want=%h", a, got_img[a], hand[a]); end
    end
    for (int a = 0; a < 52; a++) begin
      checks++;
      if (got_img[a] !== model_img[a]) begin errors++; $display("[TB] FAIL zero_image addr=%0d got=%h want=%h", a, got_img[a], model_img[a]); end
    end
    for (int a = 52; a < 64; a++) begin
      read_byte(6'(a), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL zero_out_of_range addr=%0d got=%h want=00", a, d); end
    end
  endtask

  task automatic test_opencolo;
    int done_at, done_cnt, busy_bad;
    logic [63:0] exp_ps;
    logic [15:0] chars;
    exp_ps = "OPENCOLO";
    set_inputs(16'h1234, 5'd10, 1'b1, 1'b0, 1'b1, 4'b1000, exp_ps);
    pulse_start;
    wait_build(0, done_at, done_cnt, busy_bad);
    checks++;
    if (done_at !== 325) begin errors++; $display("[TB] FAIL oc_done_cycle got=%0d want=325", done_at); end
    read_image;
    for (int a = 0; a < 52; a++) begin
      checks++;
      if (got_img[a] !== model_img[a]) begin errors++; $display("[TB] FAIL oc_image addr=%0d got=%h want=%h", a, got_img[a], model_img[a]); end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({got_img[g*13], got_img[g*13+1]} !== 16'h1234) begin
        errors++; $display("[TB] FAIL oc_pi g=%0d got=%h%h want=1234", g, got_img[g*13], got_img[g*13+1]);
      end
      checks++;
      if (got_img[g*13+3][5:0] !== 6'b000001) begin
        errors++; $display("[TB] FAIL oc_b_hi g=%0d got=%b want=000001", g, got_img[g*13+3][5:0]);
      end
      checks++;
      if (got_img[g*13+4] !== ((g == 0) ? 8'h53 : 8'h52)) begin
        errors++; $display("[TB] FAIL oc_pty_di g=%0d got=%h want=%h", g, got_img[g*13+4], (g == 0) ? 8'h53 : 8'h52);
      end
      checks++;
      if (got_img[g*13+5][7:6] !== 2'(g)) begin
        errors++; $display("[TB] FAIL oc_segment g=%0d got=%0d want=%0d", g, got_img[g*13+5][7:6], g);
      end
      chars = {got_img[g*13+9][1:0], got_img[g*13+10], got_img[g*13+11][7:2]};
      checks++;
      if (chars !== exp_ps[63-16*g -: 16]) begin
        errors++; $display("[TB] FAIL oc_chars g=%0d got=%h want=%h", g, chars, exp_ps[63-16*g -: 16]);
      end
    end
  endtask

  task automatic test_isolation;
    int prev, old_bad, new_bad;
    logic [7:0] want;
    for (int a = 0; a < 52; a++) old_img[a] = model_img[a];
    set_inputs(16'h1234, 5'd10, 1'b1, 1'b0, 1'b1, 4'b1000, "NEWNAME!");
    rds_addr = 6'd0;
    pulse_start;
    prev = -1; old_bad = 0; new_bad = 0;
    for (int c = 1; c <= 340; c++) begin
      if (prev >= 0) begin
        want = (c <= 325) ? old_img[prev] : model_img[prev];
        if (rds_data !== want) begin
          if (c <= 325) old_bad++; else new_bad++;
          if (old_bad + new_bad == 1)
            $display("[TB] first poll deviation cycle=%0d addr=%0d got=%h want=%h", c, prev, rds_data, want);
        end
      end
      prev = c % 52;
      rds_addr = 6'(prev);
      @(posedge clk); #1;
    end
    checks++;
    if (old_bad !== 0) begin errors++; $display("[TB] FAIL iso_old_image bad_reads=%0d want=0", old_bad); end
    checks++;
    if (new_bad !== 0) begin errors++; $display("[TB] FAIL iso_new_image bad_reads=%0d want=0", new_bad); end
  endtask

  task automatic test_back_to_back;
    int done_at, done_cnt, busy_bad;
    set_inputs(16'hC0DE, 5'd3, 1'b0, 1'b1, 1'b0, 4'b0101, "STATION1");
    pulse_start;
    wait_build(100, done_at, done_cnt, busy_bad);
    checks++;
    if (done_at !== 325) begin errors++; $display("[TB] FAIL b2b_done_cycle got=%0d want=325", done_at); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL b2b_done_count got=%0d want=1", done_cnt); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("[TB] FAIL b2b_busy_window bad_cycles=%0d want=0", busy_bad); end
    read_image;
    for (int a = 0; a < 52; a++) begin
      checks++;
      if (got_img[a] !== model_img[a]) begin errors++; $display("[TB] FAIL b2b_image addr=%0d got=%h want=%h", a, got_img[a], model_img[a]); end
    end
  endtask

  task automatic test_reset_mid_build;
    int done_at, done_cnt, busy_bad;
    logic [7:0] d;
    set_inputs(16'h1234, 5'd10, 1'b1, 1'b0, 1'b1, 4'b1000, "OPENCOLO");
    rds_addr = 6'd2;
    pulse_start;
    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    checks++;
    if (rds_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_data got=%h want=00", rds_data); end
    read_byte(6'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_invalid_read got=%h want=00", d); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_start busy=%b want=0", busy); end
    pulse_start;
    wait_build(0, done_at, done_cnt, busy_bad);
    checks++;
    if (done_at !== 325) begin errors++; $display("[TB] FAIL rst_rebuild_done got=%0d want=325", done_at); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("[TB] FAIL rst_rebuild_busy bad_cycles=%0d want=0", busy_bad); end
    read_image;
    for (int a = 0; a < 52; a++) begin
      checks++;
      if (got_img[a] !== model_img[a]) begin errors++; $display("[TB] FAIL rst_rebuild_image addr=%0d got=%h want=%h", a, got_img[a], model_img[a]); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    pi = '0; pty = '0; tp = 1'b0; ta = 1'b0; ms = 1'b0; di = '0; ps_name = '0;
    rds_addr = '0;
    @(posedge clk); #1;
    $display("[TB] reset");
    test_reset;
    $display("[TB] zero build");
    test_zero_build;
    $display("[TB] OPENCOLO build");
    test_opencolo;
    $display("[TB] bank isolation");
    test_isolation;
    $display("[TB] start during build");
    test_back_to_back;
    $display("[TB] reset mid build");
    test_reset_mid_build;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rds_ps_encoder.md
Name: rds_ps_encoder

Overview:
Runtime generator of the 52-byte RDS message image that the FM modulator's RDS path reads via rds_addr/rds_data. It replaces the static, file-initialised message RAM.
- From PI, PTY, flags and an 8-character Programme Service name it builds four type-0A groups: blocks A/B/C/D, each with a CRC-10 checkword and offset word.
- It writes them into a double-buffered byte RAM.
- It sits directly upstream of fmgen_test in top_fm, on the 40 MHz system clock.

Parameters:
AF_WORD, 16'hE0CD, block C content ("no AF" code 224 + filler 205).
MSG_BYTES, 52, bytes per message image (4 groups x 13 bytes).

Ports:
clk  in  1  system clock (40 MHz).
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to rebuild the message from the current inputs.
pi  in  16  programme identification code.
pty  in  5  programme type.
tp  in  1  traffic programme flag.
ta  in  1  traffic announcement flag.
ms  in  1  music/speech flag.
di  in  4  decoder identification bits; di[3] goes to segment 0.
ps_name  in  64  8 ASCII chars; char0 = ps_name[63:56].
rds_addr  in  6  read address from the RDS modulator.
rds_data  out  8  registered read data.
busy  out  1  build in progress.
done  out  1  one-cycle pulse when the new image becomes visible.

Behaviour:
Reset values:
- rds_data=0, busy=0, done=0, valid=0, display bank=0, FSM=IDLE.
- RAM contents are not reset.

Read port:
- 1-cycle latency: rds_data(t+1) = display_bank[rds_addr(t)].
- Returns 0x00 when rds_addr>=52 or valid=0.

Start handling:
- All inputs are sampled on the start cycle.
- start while busy=1 is ignored.
- busy rises the cycle after start.

Group contents, g = 0..3:
- A = pi.
- B = {4'b0000, 1'b0, tp, pty, ta, ms, di[3-g], g[1:0]}.
- C = AF_WORD.
- D = {char[2g], char[2g+1]}.

Checkword:
- CRC of the 16-bit data with generator x^10+x^8+x^7+x^5+x^4+x^3+1 (0x5B9), data MSB first, register zero at block start.
- The result is XORed with the offset word: A=0x0FC, B=0x198, C=0x168, D=0x1B4.
- Block = {data, checkword}, 26 bits.

Packing:
- A|B|C|D concatenated MSB first into 104 bits.
- Byte g*13+k holds bits [103-8k -: 8]; bit 7 is transmitted first.

FSM:
- IDLE -> CRC (16 cycles, one data bit per cycle).
- CRC -> APPEND (1 cycle: shift 26 bits into the 104-bit group register).
- After blocks A, B, C: APPEND -> CRC for the next block.
- After block D: APPEND -> WR.
- WR: 13 cycles, one byte per cycle into the back bank.
- WR -> CRC for the next group, or -> SWAP after group 3.
- SWAP: 1 cycle. Toggles the display bank, sets valid=1, pulses done, clears busy, returns to IDLE.

Timing:
- Per group: 4x17 + 13 = 81 cycles.
- done is high exactly 325 cycles after the accepted start cycle. busy is high for cycles 1..324.

Back-bank isolation:
- Writes go only to the non-displayed bank.
- Reads during a build return the old image unchanged.
- The first read of the new bank is at SWAP+1.

Reset mid-build:
- Aborts the build. Display bank and valid return to 0; the partial image is discarded.

Simultaneous events:
- rst overrides start.
- A read on the SWAP cycle returns the old bank.

Decomposition:
- rds_pkg holds:
  - CRC polynomial constant.
  - Offset constants OFS_A/B/C/D.
  - GROUP_BYTES=13, NUM_GROUPS=4.
  - FSM state enum.
  - typedef rds_block_t (26-bit).
- Sub-module rds_crc10: serial CRC-10 with clear, shift-enable, data bit in, 10-bit crc out. Instantiated once.
- The 2x52x8 RAM is inferred inline as a simple dual-port.

Test Plan:
- Reset, then read addr 0..63 -> rds_data=0x00 everywhere (valid=0); busy=0, done=0.
- pi=0, pty=0, tp=ta=ms=0, di=0, ps_name=0, start:
  - done at cycle 325; busy high for cycles 1..324.
  - Bytes 0,1=0x00; byte 2=0x3F (OFS_A bits 9:2); byte 3=0x00.
  - Addresses 52..63 read 0x00.
- pi=0x1234, pty=10, tp=1, ms=1, di=4'b1000, ps_name="OPENCOLO":
  - All 52 bytes match a bit-accurate bench model of the CRC and packing.
  - Segment field in group g = g; DI bit set only in group 0.
  - D-block bytes decode to "OP","EN","CO","LO".
- During a second build with a new ps_name, poll all addresses continuously:
  - Old image returned until done.
  - New image from the cycle after done.
  - No mixed content.
- Second start pulse at cycle 100 of a build -> ignored; done still at 325, only one done pulse.
- rst asserted at cycle 200 of a build:
  - busy=0, rds_data=0x00 next cycle.
  - A fresh start completes normally in 325 cycles.
